led_playback_sequencer: RTL and testbench
=========================================

// Module: led_playback_sequencer
// PURPOSE
//  Plays a stored colour sequence on the four game LEDs. Given a last index, it walks
//  sequence memory from address 0 and lights one LED per entry for a speed-dependent ON time,
//  then holds all LEDs dark for a gap. It sits between the game controller (start/abort/done)
//  and memory_module (read port), and owns the mem_rd/addr slot while busy.
// PARAMETERS
//  ADDR_WIDTH      5    sequence memory address width (max 32 steps)
//  COLOR_CODEFY_W  2    colour code width
//  FAST_ON_CYCLES  12_500_000  LED ON cycles when speed=1
//  SLOW_ON_CYCLES  25_000_000  LED ON cycles when speed=0
//  GAP_CYCLES      6_250_000   all-dark cycles after each step
//  TIMER_W         25   timer width; must hold max(FAST_ON,SLOW_ON,GAP)-1
// PORTS
//  clk          in   1               system clock, rising edge
//  rst          in   1               synchronous reset, active-high
//  play_start   in   1               1-cycle request to start playback (sampled only in IDLE)
//  play_abort   in   1               stop playback immediately
//  last_index   in   ADDR_WIDTH      index of final step to play (plays 0..last_index)
//  speed        in   1               1=fast, 0=slow; latched on accepted play_start
//  flash_req    in   1               fail-flash request (see CONFIGURATION)
//  mem_rd       out  1               memory read strobe
//  mem_addr     out  ADDR_WIDTH      memory address
//  mem_data     in   COLOR_CODEFY_W  memory read data, valid 1 cycle after mem_rd
//  led_green    out  1               LED for code 2'b00
//  led_red      out  1               LED for code 2'b01
//  led_blue     out  1               LED for code 2'b10
//  led_yellow   out  1               LED for code 2'b11
//  busy         out  1               high in every state except IDLE
//  done         out  1               1-cycle pulse when the last step's gap completes
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; index, timer, colour and speed registers cleared.
//  - Reset has priority over all inputs, including mid-playback (LEDs dark next cycle).
//  - FSM: IDLE -> FETCH -> WAIT_DATA -> LED_ON -> LED_OFF -> (FETCH | DONE) -> IDLE.
//  - IDLE: on play_start, latch speed, clear index, go to FETCH.
//  - FETCH (1 cycle): mem_rd=1, mem_addr=index. mem_rd=0 in all other states.
//  - WAIT_DATA (1 cycle): capture mem_data into colour register; load timer.
//  - LED_ON: lasts exactly ON cycles (FAST_ON or SLOW_ON per latched speed); the decoded LED
//    is 1; the other three are 0.
//  - LED_OFF: lasts exactly GAP_CYCLES, with all LEDs 0. At the end, if index==last_index go to
//    DONE, else index+1 and go to FETCH.
//  - DONE (1 cycle): done=1, busy=1; then IDLE.
//  - Per step: 2+ON+GAP cycles. Accepted start at edge k gives FETCH at cycle k+1 and
//    DONE at cycle k+1+(last_index+1)*(2+ON+GAP).
//  - last_index is sampled every LED_OFF end (not latched); the controller holds it stable.
//  - Index never wraps: the maximum last_index (2^ADDR_WIDTH-1) plays every entry, then DONE.
//  - play_start while busy is ignored.
//  - play_abort in any non-IDLE state: next cycle IDLE, LEDs 0, mem_rd 0, no done pulse.
//  - play_start and play_abort together in IDLE: abort wins; stay IDLE.
//  - Timer counts down from N-1 to 0, then advances; timer width arithmetic is unsigned,
//    with no wrap inside a phase.
//  - All outputs are registered or decoded from state/colour registers only (glitch-free).
// CONFIGURATION
//  GENIUS_FAIL_FLASH_EN defined: flash_req in IDLE (abort low) enters FLASH. All four LEDs
//    are 1 for SLOW_ON_CYCLES, then 0 for GAP_CYCLES, then IDLE. busy=1 during this and no
//    done pulse. play_start is ignored during FLASH; play_abort exits to IDLE.
//    play_start and flash_req together in IDLE: play_start wins.
//  Undefined: flash_req is ignored, and the FLASH state and its logic are not built.
// TESTING (bench params FAST_ON=4, SLOW_ON=8, GAP=2, TIMER_W=4)
//  1. Memory {0:2'b01,1:2'b11,2:2'b00}, last_index=2, speed=1, start pulse at k ->
//     red on cycles k+3..k+6, yellow k+11..k+14, green k+19..k+22; done=1 only at k+25.
//  2. Same with speed=0 -> each LED on 8 cycles; done at k+37. Flip speed mid-run -> no change.
//  3. Abort during 2nd LED_ON -> next cycle all LEDs 0, busy 0, done never pulses;
//     a new start then replays from addr 0.
//  4. last_index=31, all entries 2'b10 -> 32 blue pulses, mem_addr 0..31, no wrap to 0,
//     single done pulse.
//  5. rst=1 mid LED_ON -> next cycle all outputs 0; a start during busy is ignored
//     (mem_addr sequence unchanged).
//  6. With GENIUS_FAIL_FLASH_EN: flash_req in IDLE -> all LEDs 1 for 8 cycles, 0 for 2,
//     then IDLE, no done. Without the macro: flash_req leaves outputs at 0.

Source files
------------

// File: rtl/led_playback_sequencer.sv
// Plays sequence memory entries 0..last_index as one LED pulse each, followed by a dark gap.
// Optional GENIUS_FAIL_FLASH_EN builds an all-LED fail flash started by flash_req from IDLE.
module led_playback_sequencer #(
    parameter int ADDR_WIDTH     = 5,
    parameter int COLOR_CODEFY_W = 2,
    parameter int FAST_ON_CYCLES = 12_500_000,
    parameter int SLOW_ON_CYCLES = 25_000_000,
    parameter int GAP_CYCLES     = 6_250_000,
    parameter int TIMER_W        = 25
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      play_start,
    input  logic                      play_abort,
    input  logic [ADDR_WIDTH-1:0]     last_index,
    input  logic                      speed,
    input  logic                      flash_req,
    output logic                      mem_rd,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [COLOR_CODEFY_W-1:0] mem_data,
    output logic                      led_green,
    output logic                      led_red,
    output logic                      led_blue,
    output logic                      led_yellow,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_LED_ON    = 3'd3,
        S_LED_OFF   = 3'd4,
        S_DONE      = 3'd5
`ifdef GENIUS_FAIL_FLASH_EN
        ,
        S_FLASH_ON  = 3'd6,
        S_FLASH_OFF = 3'd7
`endif
    } state_t;

    // Timers count down from N-1 to zero, so each phase lasts exactly N cycles
    localparam logic [TIMER_W-1:0]        FAST_LOAD  = TIMER_W'(FAST_ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0]        SLOW_LOAD  = TIMER_W'(SLOW_ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0]        GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0]        TIMER_ZERO = TIMER_W'(0);
    localparam logic [TIMER_W-1:0]        TIMER_ONE  = TIMER_W'(1);
    localparam logic [ADDR_WIDTH-1:0]     INDEX_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0]     INDEX_ONE  = ADDR_WIDTH'(1);
    localparam logic [COLOR_CODEFY_W-1:0] CODE_GREEN = COLOR_CODEFY_W'(0);
    localparam logic [COLOR_CODEFY_W-1:0] CODE_RED   = COLOR_CODEFY_W'(1);
    localparam logic [COLOR_CODEFY_W-1:0] CODE_BLUE  = COLOR_CODEFY_W'(2);
    localparam logic [COLOR_CODEFY_W-1:0] CODE_YELL  = COLOR_CODEFY_W'(3);

    state_t                      state_r;
    logic [ADDR_WIDTH-1:0]       index_r;
    logic [TIMER_W-1:0]          timer_r;
    logic [COLOR_CODEFY_W-1:0]   colour_r;
    logic                        speed_r;

`ifndef GENIUS_FAIL_FLASH_EN
    logic unused_flash_s;
    assign unused_flash_s = flash_req;
`endif

    // Sequencer state, step index, phase timer and latched colour/speed
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            index_r  <= INDEX_ZERO;
            timer_r  <= TIMER_ZERO;
            colour_r <= CODE_GREEN;
            speed_r  <= 1'b0;
        end else if (play_abort) begin
            // Abort wins in every state, including a simultaneous start in IDLE
            state_r <= S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (play_start) begin
                        speed_r <= speed;
                        index_r <= INDEX_ZERO;
                        state_r <= S_FETCH;
`ifdef GENIUS_FAIL_FLASH_EN
                    end else if (flash_req) begin
                        timer_r <= SLOW_LOAD;
                        state_r <= S_FLASH_ON;
`endif
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    state_r <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    colour_r <= mem_data;
                    timer_r  <= speed_r ? FAST_LOAD : SLOW_LOAD;
                    state_r  <= S_LED_ON;
                end
                S_LED_ON: begin
                    if (timer_r == TIMER_ZERO) begin
                        timer_r <= GAP_LOAD;
                        state_r <= S_LED_OFF;
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end
                S_LED_OFF: begin
                    if (timer_r != TIMER_ZERO) begin
                        timer_r <= timer_r - TIMER_ONE;
                    end else if (index_r == last_index) begin
                        state_r <= S_DONE;
                    end else begin
                        index_r <= index_r + INDEX_ONE;
                        state_r <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
`ifdef GENIUS_FAIL_FLASH_EN
                S_FLASH_ON: begin
                    if (timer_r == TIMER_ZERO) begin
                        timer_r <= GAP_LOAD;
                        state_r <= S_FLASH_OFF;
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end
                S_FLASH_OFF: begin
                    if (timer_r == TIMER_ZERO) begin
                        state_r <= S_IDLE;
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end
`endif
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // LED decode from state and colour registers only
    always_comb begin
        led_green  = 1'b0;
        led_red    = 1'b0;
        led_blue   = 1'b0;
        led_yellow = 1'b0;
        case (state_r)
            S_LED_ON: begin
                case (colour_r)
                    CODE_GREEN: led_green  = 1'b1;
                    CODE_RED:   led_red    = 1'b1;
                    CODE_BLUE:  led_blue   = 1'b1;
                    CODE_YELL:  led_yellow = 1'b1;
                    default:    led_green  = 1'b0;
                endcase
            end
`ifdef GENIUS_FAIL_FLASH_EN
            S_FLASH_ON: begin
                led_green  = 1'b1;
                led_red    = 1'b1;
                led_blue   = 1'b1;
                led_yellow = 1'b1;
            end
`endif
            default: begin
                led_green = 1'b0;
            end
        endcase
    end

    assign mem_rd   = (state_r == S_FETCH);
    assign mem_addr = index_r;
    assign busy     = (state_r != S_IDLE);
    assign done     = (state_r == S_DONE);

endmodule

// File: tb/tb_led_playback_sequencer.sv
// Randomized bench for led_playback_sequencer; expected outputs come from a per-cycle
// arithmetic model of the playback timeline (step = t / period, phase = t % period).
module tb_led_playback_sequencer;

    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int FAST = 4;
    localparam int SLOW = 8;
    localparam int GAP  = 2;
    localparam int TW   = 4;

    logic          clk = 1'b0;
    logic          rst, play_start, play_abort, speed, flash_req;
    logic [AW-1:0] last_index, mem_addr;
    logic          mem_rd;
    logic [CW-1:0] mem_data = '0;
    logic          led_green, led_red, led_blue, led_yellow, busy, done;
    logic [CW-1:0] mem [0:31];
    int            cyc    = 0;
    int            n_vec  = 0;
    int            n_miss = 0;

    led_playback_sequencer #(
        .ADDR_WIDTH(AW), .COLOR_CODEFY_W(CW), .FAST_ON_CYCLES(FAST),
        .SLOW_ON_CYCLES(SLOW), .GAP_CYCLES(GAP), .TIMER_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .play_start(play_start), .play_abort(play_abort),
        .last_index(last_index), .speed(speed), .flash_req(flash_req),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .led_green(led_green), .led_red(led_red), .led_blue(led_blue),
        .led_yellow(led_yellow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Sequence memory: data valid one cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [6:0] out_vec();
        return {busy, done, mem_rd, led_yellow, led_blue, led_red, led_green};
    endfunction

    // Expected {busy,done,mem_rd,yellow,blue,red,green} t cycles after the accepted start edge
    function automatic logic [6:0] exp_play(input int t, input int last, input bit spd);
        int on, p, s, r;
        on = spd ? FAST : SLOW;
        p  = 2 + on + GAP;
        s  = t / p;
        r  = t % p;
        if (t < 0 || t > (last + 1) * p) return 7'b0000000;
        if (t == (last + 1) * p)         return 7'b1100000;
        if (r == 0)                      return 7'b1010000;
        if (r < 2)                       return 7'b1000000;
        if (r < 2 + on)                  return 7'b1000000 | (7'd1 << mem[s]);
        return 7'b1000000;
    endfunction

    // kill_mode: 0 none, 1 abort, 2 reset; kill_off < 0 picks a random offset
    task automatic play_run(input int last, input bit spd, input int kill_mode, input int kill_off);
        int p, run_len, t, start_edge, off;
        bit killed;
        logic [6:0] exp;
        p       = 2 + (spd ? FAST : SLOW) + GAP;
        run_len = (last + 1) * p;
        off     = (kill_off < 0) ? int'($urandom_range(1, run_len)) : kill_off;
        last_index = AW'(last);
        speed      = spd;
        play_start = 1'b1;
        start_edge = cyc + 1;
        step();
        play_start = 1'b0;
        for (int i = 0; i < run_len + 4; i++) begin
            t      = cyc - start_edge;
            killed = (kill_mode != 0) && (t >= off);
            exp    = killed ? 7'b0000000 : exp_play(t, last, spd);
            check_val("outputs", {25'd0, out_vec()}, {25'd0, exp});
            if (exp[4]) check_val("mem_addr", {27'd0, mem_addr}, t / p);
            if (killed && kill_mode == 2) check_val("rst_addr", {27'd0, mem_addr}, 32'd0);
            speed      = 1'($urandom);
            play_start = !killed && (t < run_len) && ($urandom_range(0, 7) == 0);
            play_abort = (kill_mode == 1) && (t + 1 == off);
            rst        = (kill_mode == 2) && (t + 1 == off);
            step();
        end
        play_start = 1'b0;
        play_abort = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        rst = 1'b1; play_start = 1'b0; play_abort = 1'b0; speed = 1'b0; flash_req = 1'b0;
        last_index = '0;
        for (int i = 0; i < 32; i++) mem[i] = CW'($urandom);
        step();
        step();
        check_val("reset_outputs", {25'd0, out_vec()}, 32'd0);
        check_val("reset_addr", {27'd0, mem_addr}, 32'd0);
        rst = 1'b0;
        step();
        check_val("idle_outputs", {25'd0, out_vec()}, 32'd0);

        mem[0] = 2'b01; mem[1] = 2'b11; mem[2] = 2'b00;
        play_run(2, 1'b1, 0, 0);
        play_run(2, 1'b0, 0, 0);
        play_run(2, 1'b1, 1, 11);
        play_run(2, 1'b1, 0, 0);
        for (int i = 0; i < 32; i++) mem[i] = 2'b10;
        play_run(31, 1'b1, 0, 0);
        play_run(3, 1'b0, 2, 4);

        // Start and abort together in IDLE: abort wins
        play_start = 1'b1; play_abort = 1'b1;
        step();
        play_start = 1'b0; play_abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("abort_vs_start", {25'd0, out_vec()}, 32'd0);
            step();
        end

        flash_req = 1'b1;
        step();
        flash_req = 1'b0;
        for (int i = 0; i < 14; i++) begin
`ifdef GENIUS_FAIL_FLASH_EN
            check_val("flash", {25'd0, out_vec()},
                      (i < SLOW) ? 32'h4F : (i < SLOW + GAP) ? 32'h40 : 32'h00);
`else
            check_val("flash_ignored", {25'd0, out_vec()}, 32'd0);
`endif
            step();
        end

        for (int r = 0; r < 14; r++) begin
            int mode;
            for (int i = 0; i < 32; i++) mem[i] = CW'($urandom);
            mode = ($urandom_range(0, 3) == 0) ? 1 : ($urandom_range(0, 5) == 0) ? 2 : 0;
            play_run((r == 5) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 6)),
                     1'($urandom), mode, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
